// File: rtl/nonogram_pkg.sv
// Shared definitions for the nonogram board stream: flag codes, encoder states, message type.
package nonogram_pkg;

   localparam logic [2:0] FLAG_START_BOARD = 3'b111;
   localparam logic [2:0] FLAG_END_BOARD   = 3'b000;
   localparam logic [2:0] FLAG_START_LINE  = 3'b110;
   localparam logic [2:0] FLAG_END_LINE    = 3'b001;
   localparam logic [2:0] FLAG_AND         = 3'b101;
   localparam logic [2:0] FLAG_OR          = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_N,
      ST_HDR_M,
      ST_LINE_START,
      ST_WAIT_OPT,
      ST_CELLS,
      ST_SEP,
      ST_BOARD_END
   } enc_state_t;

   typedef struct packed {
      logic [2:0] flag;
      logic [7:0] payload;
   } msg_t;

   // Flag byte on the wire: flag code in the top three bits.
   function automatic logic [7:0] flag_byte(input logic [2:0] flag);
      return {flag, 5'b0_0000};
   endfunction

endpackage

// File: rtl/msg_tx.sv
// Serialises one msg_t into a flag byte then a payload byte over a valid/ready byte port.
// A new message is accepted in the same cycle the previous payload byte leaves, so back-to-back messages have no gap.
module msg_tx
   import nonogram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       msg_vld,
   output logic       msg_rdy,
   input  msg_t       msg,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       sent
);

   logic       phase;
   logic [7:0] payload_q;
   logic       byte_hs;

   assign byte_hs = byte_valid && byte_ready;
   assign msg_rdy = !byte_valid || (phase && byte_ready);
   assign sent    = byte_hs && phase;

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_valid <= 1'b0;
         byte_out   <= 8'h00;
         payload_q  <= 8'h00;
         phase      <= 1'b0;
      end else if (msg_vld && msg_rdy) begin
         byte_valid <= 1'b1;
         byte_out   <= flag_byte(msg.flag);
         payload_q  <= msg.payload;
         phase      <= 1'b0;
      end else if (byte_hs) begin
         if (!phase) begin
            byte_out <= payload_q;
            phase    <= 1'b1;
         end else begin
            byte_valid <= 1'b0;
            phase      <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/board_encoder.sv
// Walks a nonogram board (headers, rows then columns, options, cells) and hands each message to msg_tx.
// One option bitmap is accepted per WAIT_OPT visit; the byte stream otherwise runs at one byte per cycle.
module board_encoder
   import nonogram_pkg::*;
#(
   parameter int MAX_ROWS = 11,
   parameter int MAX_COLS = 11,
   parameter int MAX_LEN  = 11
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [$clog2(MAX_COLS)-1:0]   n_in,
   input  logic [$clog2(MAX_ROWS)-1:0]   m_in,
   input  logic                          opt_valid,
   output logic                          opt_ready,
   input  logic [MAX_LEN-1:0]            opt_bits,
   input  logic                          opt_last,
   output logic [7:0]                    byte_out,
   output logic                          byte_valid,
   input  logic                          byte_ready,
   output logic                          busy,
   output logic                          done
);

   localparam int NW = $clog2(MAX_COLS);
   localparam int MW = $clog2(MAX_ROWS);
   localparam int LW = $clog2(MAX_ROWS + MAX_COLS + 1);

   enc_state_t         state;
   logic [NW-1:0]      n_q;
   logic [MW-1:0]      m_q;
   logic [LW-1:0]      line_idx;
   logic [3:0]         cell_idx;
   logic [MAX_LEN-1:0] bits_q;
   logic               last_q;
   logic               end_sent;

   msg_t msg;
   logic msg_vld;
   logic msg_rdy;
   logic msg_hs;
   logic sent;

   logic [4:0] line_len;
   logic       zero_dim;
   logic       last_cell;
   logic       last_line;

   // Rows (lines 0..m-1) hold n cells, columns hold m cells.
   assign line_len  = (line_idx < LW'(m_q)) ? 5'(n_q) : 5'(m_q);
   assign zero_dim  = (n_q == '0) || (m_q == '0);
   assign last_cell = ({1'b0, cell_idx} == (line_len - 5'd1));
   assign last_line = (line_idx == (LW'(m_q) + LW'(n_q) - LW'(1)));

   assign opt_ready = (state == ST_WAIT_OPT) && !byte_valid;
   assign msg_hs    = msg_vld && msg_rdy;

   // The first AND is offered straight from opt_bits so it loads on the accept edge.
   always_comb begin
      msg_vld     = 1'b0;
      msg.flag    = FLAG_END_BOARD;
      msg.payload = 8'h00;
      case (state)
         ST_HDR_N: begin
            msg_vld     = 1'b1;
            msg.flag    = FLAG_START_BOARD;
            msg.payload = {2'b00, 5'(n_q), 1'b0};
         end
         ST_HDR_M: begin
            msg_vld     = 1'b1;
            msg.flag    = FLAG_START_BOARD;
            msg.payload = {2'b00, 5'(m_q), 1'b0};
         end
         ST_LINE_START: begin
            msg_vld  = 1'b1;
            msg.flag = FLAG_START_LINE;
         end
         ST_WAIT_OPT: begin
            msg_vld     = opt_valid && opt_ready;
            msg.flag    = FLAG_AND;
            msg.payload = {3'b000, 4'd0, opt_bits[0]};
         end
         ST_CELLS: begin
            msg_vld     = 1'b1;
            msg.flag    = FLAG_AND;
            msg.payload = {3'b000, cell_idx, bits_q[cell_idx]};
         end
         ST_SEP: begin
            msg_vld  = 1'b1;
            msg.flag = last_q ? FLAG_END_LINE : FLAG_OR;
         end
         ST_BOARD_END: begin
            msg_vld  = !end_sent;
            msg.flag = FLAG_END_BOARD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         n_q      <= '0;
         m_q      <= '0;
         line_idx <= '0;
         cell_idx <= 4'd0;
         bits_q   <= '0;
         last_q   <= 1'b0;
         end_sent <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  n_q      <= n_in;
                  m_q      <= m_in;
                  line_idx <= '0;
                  cell_idx <= 4'd0;
                  end_sent <= 1'b0;
                  busy     <= 1'b1;
                  state    <= ST_HDR_N;
               end
            end
            ST_HDR_N: begin
               if (msg_hs) state <= ST_HDR_M;
            end
            ST_HDR_M: begin
               if (msg_hs) state <= zero_dim ? ST_BOARD_END : ST_LINE_START;
            end
            ST_LINE_START: begin
               if (msg_hs) state <= ST_WAIT_OPT;
            end
            ST_WAIT_OPT: begin
               if (msg_hs) begin
                  bits_q   <= opt_bits;
                  last_q   <= opt_last;
                  cell_idx <= 4'd1;
                  state    <= (line_len == 5'd1) ? ST_SEP : ST_CELLS;
               end
            end
            ST_CELLS: begin
               if (msg_hs) begin
                  if (last_cell) state <= ST_SEP;
                  else cell_idx <= cell_idx + 4'd1;
               end
            end
            ST_SEP: begin
               if (msg_hs) begin
                  if (!last_q) begin
                     state <= ST_WAIT_OPT;
                  end else if (last_line) begin
                     state <= ST_BOARD_END;
                  end else begin
                     line_idx <= line_idx + LW'(1);
                     state    <= ST_LINE_START;
                  end
               end
            end
            ST_BOARD_END: begin
               if (msg_hs) end_sent <= 1'b1;
               // sent only counts once END_BOARD is the message in flight
               if (end_sent && sent) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   msg_tx u_msg_tx (
      .clk        (clk),
      .rst        (rst),
      .msg_vld    (msg_vld),
      .msg_rdy    (msg_rdy),
      .msg        (msg),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .sent       (sent)
   );

endmodule

// File: tb/tb_board_encoder.sv
// Bench for board_encoder: board-level byte streams against a list-based reference model.
module tb_board_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  n_in;
   logic [3:0]  m_in;
   logic        opt_valid;
   logic        opt_ready;
   logic [10:0] opt_bits;
   logic        opt_last;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready;
   logic        busy;
   logic        done;

   board_encoder #(.MAX_ROWS(11), .MAX_COLS(11), .MAX_LEN(11)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .n_in       (n_in),
      .m_in       (m_in),
      .opt_valid  (opt_valid),
      .opt_ready  (opt_ready),
      .opt_bits   (opt_bits),
      .opt_last   (opt_last),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] bits;
      bit          last;
   } opt_t;

   typedef struct {
      int n;
      int m;
      int duty;
      int exp_bytes;
      int exp_ands;
      bit exp_rdy;
   } vec_t;

   opt_t       opts[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         total = 0;
   int         bad = 0;
   bit         last_rdy_seen;

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, need %0h", name, got, exp);
      end
   endtask

   // Reference stream: walk the line list and the option list in order.
   function automatic void build_expected(input int n, input int m);
      int   k;
      int   len;
      bit   more;
      opt_t o;
      exp_q.delete();
      exp_q.push_back(8'hE0); exp_q.push_back(8'(n * 2));
      exp_q.push_back(8'hE0); exp_q.push_back(8'(m * 2));
      if (n > 0 && m > 0) begin
         k = 0;
         for (int l = 0; l < m + n; l++) begin
            len = (l < m) ? n : m;
            exp_q.push_back(8'hC0); exp_q.push_back(8'h00);
            more = 1'b1;
            while (more) begin
               o = opts[k];
               k++;
               for (int c = 0; c < len; c++) begin
                  exp_q.push_back(8'hA0);
                  exp_q.push_back(8'(c * 2 + int'(o.bits[c])));
               end
               exp_q.push_back(o.last ? 8'h20 : 8'h40); exp_q.push_back(8'h00);
               more = !o.last;
            end
         end
      end
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
   endfunction

   function automatic void gen_opts(input int n, input int m, input int maxopt);
      int   nopt;
      opt_t o;
      opts.delete();
      if (n > 0 && m > 0) begin
         for (int l = 0; l < m + n; l++) begin
            nopt = $urandom_range(1, maxopt);
            for (int i = 0; i < nopt; i++) begin
               o.bits = 11'($urandom);
               o.last = (i == nopt - 1);
               opts.push_back(o);
            end
         end
      end
   endfunction

   function automatic int count_flag(input logic [7:0] f);
      int cnt = 0;
      for (int i = 0; i < got_q.size(); i += 2)
         if (got_q[i] == f) cnt++;
      return cnt;
   endfunction

   task automatic run_board(input int n, input int m, input int duty, input bit spam, input string tag);
      int         k = 0;
      int         done_cnt = 0;
      int         extra = -1;
      int         phantom = 0;
      bit         hold = 1'b0;
      logic [7:0] held = 8'h00;
      build_expected(n, m);
      got_q.delete();
      last_rdy_seen = 1'b0;
      for (int cyc = 0; cyc < 8000 && extra != 0; cyc++) begin
         @(negedge clk);
         start      = (cyc == 0) || (spam && busy && $urandom_range(0, 3) == 0);
         n_in       = (cyc == 0) ? 4'(n) : 4'($urandom);
         m_in       = (cyc == 0) ? 4'(m) : 4'($urandom);
         byte_ready = ($urandom_range(1, 100) <= duty);
         if (k < opts.size()) begin
            opt_valid = 1'b1;
            opt_bits  = opts[k].bits;
            opt_last  = opts[k].last;
         end else begin
            opt_valid = spam;
            opt_bits  = 11'($urandom);
            opt_last  = 1'($urandom);
         end
         #1;
         if (hold) check({tag, " hold"}, {byte_valid, byte_out}, {1'b1, held});
         hold = byte_valid && !byte_ready;
         held = byte_out;
         if (byte_valid && byte_ready) got_q.push_back(byte_out);
         if (opt_valid && opt_ready) begin
            if (k < opts.size()) k++;
            else phantom++;
         end
         if (opt_ready) last_rdy_seen = 1'b1;
         if (cyc == 1) check({tag, " busy"}, busy, 1);
         if (done) done_cnt++;
         if (extra > 0) extra--;
         else if (extra < 0 && done) begin
            check({tag, " busy_at_done"}, busy, 0);
            extra = 2;
         end
      end
      start = 1'b0;
      opt_valid = 1'b0;
      check({tag, " finished"}, int'(extra == 0), 1);
      check({tag, " nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s byte%0d", tag, i), (i < got_q.size()) ? int'(got_q[i]) : -1, exp_q[i]);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " opts_used"}, k, opts.size());
      check({tag, " phantom_opt"}, phantom, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: got no finish, need finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      vec_t       vt[8];
      logic [7:0] t1[26];
      opt_t       o;
      int         seen;
      int         duty;

      rst = 1'b1; start = 1'b0; n_in = 4'd0; m_in = 4'd0;
      opt_valid = 1'b0; opt_bits = 11'd0; opt_last = 1'b0; byte_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst byte_valid", byte_valid, 0);
      check("rst byte_out", byte_out, 0);
      check("rst opt_ready", opt_ready, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      // Table: one option per line; byte and AND-message counts derived by hand.
      vt[0] = '{n: 0,  m: 3,  duty: 100, exp_bytes: 6,   exp_ands: 0,   exp_rdy: 1'b0};
      vt[1] = '{n: 3,  m: 0,  duty: 100, exp_bytes: 6,   exp_ands: 0,   exp_rdy: 1'b0};
      vt[2] = '{n: 0,  m: 0,  duty: 100, exp_bytes: 6,   exp_ands: 0,   exp_rdy: 1'b0};
      vt[3] = '{n: 1,  m: 1,  duty: 100, exp_bytes: 18,  exp_ands: 2,   exp_rdy: 1'b1};
      vt[4] = '{n: 2,  m: 2,  duty: 30,  exp_bytes: 38,  exp_ands: 8,   exp_rdy: 1'b1};
      vt[5] = '{n: 5,  m: 3,  duty: 100, exp_bytes: 98,  exp_ands: 30,  exp_rdy: 1'b1};
      vt[6] = '{n: 1,  m: 11, duty: 60,  exp_bytes: 98,  exp_ands: 22,  exp_rdy: 1'b1};
      vt[7] = '{n: 11, m: 11, duty: 100, exp_bytes: 578, exp_ands: 242, exp_rdy: 1'b1};
      for (int v = 0; v < 8; v++) begin
         gen_opts(vt[v].n, vt[v].m, 1);
         run_board(vt[v].n, vt[v].m, vt[v].duty, 1'b0, $sformatf("vec%0d", v));
         check($sformatf("vec%0d count", v), got_q.size(), vt[v].exp_bytes);
         check($sformatf("vec%0d ands", v), count_flag(8'hA0), vt[v].exp_ands);
         check($sformatf("vec%0d rdy_seen", v), last_rdy_seen, vt[v].exp_rdy);
      end

      // Small board with known bytes; upper option bits carry junk that must be ignored.
      t1 = '{8'hE0, 8'h04, 8'hE0, 8'h02, 8'hC0, 8'h00, 8'hA0, 8'h01, 8'hA0, 8'h02, 8'h20, 8'h00,
             8'hC0, 8'h00, 8'hA0, 8'h01, 8'h20, 8'h00, 8'hC0, 8'h00, 8'hA0, 8'h01, 8'h20, 8'h00,
             8'h00, 8'h00};
      opts.delete();
      o.last = 1'b1;
      o.bits = 11'h7FD; opts.push_back(o);
      o.bits = 11'h401; opts.push_back(o);
      o.bits = 11'h003; opts.push_back(o);
      run_board(2, 1, 100, 1'b0, "t1");
      for (int i = 0; i < 26; i++)
         check($sformatf("t1 lit%0d", i), (i < got_q.size()) ? int'(got_q[i]) : -1, t1[i]);

      // Three options on the first line: two ORs then END_LINE.
      opts.delete();
      o.last = 1'b0;
      o.bits = 11'($urandom); opts.push_back(o);
      o.bits = 11'($urandom); opts.push_back(o);
      o.last = 1'b1;
      o.bits = 11'($urandom); opts.push_back(o);
      o.bits = 11'($urandom); opts.push_back(o);
      o.bits = 11'($urandom); opts.push_back(o);
      run_board(2, 1, 100, 1'b0, "t2");
      check("t2 or_count", count_flag(8'h40), 2);
      check("t2 end_line_count", count_flag(8'h20), 3);

      // Slow sink plus start pulses and opt_valid held through the headers.
      gen_opts(3, 2, 3);
      run_board(3, 2, 30, 1'b1, "t35");

      // Reset in the middle of a line's cells, then a fresh board.
      @(negedge clk);
      n_in = 4'd5; m_in = 4'd4; start = 1'b1; byte_ready = 1'b1;
      opt_valid = 1'b1; opt_bits = 11'($urandom); opt_last = 1'b0;
      seen = 0;
      for (int c = 0; c < 200 && seen < 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (byte_valid && byte_out == 8'hA0) seen++;
      end
      check("t4 reached_cells", seen, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("t4 byte_valid", byte_valid, 0);
      check("t4 busy", busy, 0);
      check("t4 opt_ready", opt_ready, 0);
      check("t4 done", done, 0);
      rst = 1'b0;
      opt_valid = 1'b0;
      gen_opts(1, 2, 2);
      run_board(1, 2, 100, 1'b0, "t4fresh");

      for (int r = 0; r < 8; r++) begin
         int n;
         int m;
         n = $urandom_range(0, 7);
         m = $urandom_range(0, 7);
         case ($urandom_range(0, 2))
            0:       duty = 30;
            1:       duty = 60;
            default: duty = 100;
         endcase
         gen_opts(n, m, 3);
         run_board(n, m, duty, 1'($urandom), $sformatf("rnd%0d", r));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
